// File: rtl/gpio_apb_banked_if.sv
// rtl/gpio_apb_banked_if.sv - APB bus bundle for the banked GPIO peripheral
//
// Purpose: groups the APB request (paddr, pwdata, pwrite, psel, penable, pstrb)
//          and response (prdata, pready, pslverr) signals of one APB link.
// Ports  : master modport drives the request and samples the response;
//          slave modport samples the request and drives the response.

interface gpio_apb_banked_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic                    pwrite;
    logic                    psel;
    logic                    penable;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/gpio_apb_banked.sv
// rtl/gpio_apb_banked.sv - banked APB GPIO with sync, debounce and edge interrupts
//
// Purpose: NrGPIOs pins in DATA_WIDTH-bit banks behind a zero-wait-state APB slave.
//          Register offset = reg*0x40 + bank*4:
//          0 DIR, 1 OUT, 2 OUT_SET, 3 OUT_CLR, 4 IN, 5 RISE_EN, 6 FALL_EN,
//          7 STATUS (W1C), 8 DEBOUNCE (bank 0 only).
// Ports  : clk_i, rst_i (async, active-high)
//          gpio_in        raw asynchronous pad inputs
//          gpio_out       OUT register
//          gpio_tx_en_o   DIR register (1 = output)
//          gpio_in_sync_o synchronised + debounced inputs
//          interrupt_o    OR of all STATUS bits
//          apb            APB slave link

module gpio_apb_banked #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NrGPIOs       = 64,
    parameter int DebounceWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NrGPIOs-1:0]   gpio_in,
    output logic [NrGPIOs-1:0]   gpio_out,
    output logic [NrGPIOs-1:0]   gpio_tx_en_o,
    output logic [NrGPIOs-1:0]   gpio_in_sync_o,
    output logic                 interrupt_o,
    gpio_apb_banked_if.slave     apb
);
    localparam int NrBanks = (NrGPIOs + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PadW    = NrBanks * DATA_WIDTH;

    // Register file, kept bank-padded so bank slices line up with APB words
    logic [PadW-1:0]          dir_q, out_q, rise_en_q, fall_en_q, status_q;
    logic [DebounceWidth-1:0] debounce_q, presc_q;

    // Input path
    logic [NrGPIOs-1:0] sync1_q, sync2_q, sample_q, filt_reg_q, filt_q;

    // ---------------- address decode ----------------
    logic [ADDR_WIDTH-7:0] reg_idx;
    logic [3:0]            bank_idx;
    logic [3:0]            reg_sel;
    logic                  access, err, wr_en;
    logic                  unused_addr_bits;

    assign reg_idx  = apb.paddr[ADDR_WIDTH-1:6];
    assign bank_idx = apb.paddr[5:2];
    assign reg_sel  = reg_idx[3:0];
    assign unused_addr_bits = ^{apb.paddr[1:0], apb.pstrb};

    assign access = apb.psel & apb.penable;
    assign err    = (reg_idx > (ADDR_WIDTH-6)'(8))
                  | (int'(bank_idx) >= NrBanks)
                  | ((reg_sel == 4'd8) & (bank_idx != 4'd0))
                  | (apb.pwrite & (reg_sel == 4'd4));
    assign wr_en  = access & apb.pwrite & ~err;

    logic wr_dir, wr_out, wr_set, wr_clr, wr_rise, wr_fall, wr_stat, wr_deb;
    assign wr_dir  = wr_en & (reg_sel == 4'd0);
    assign wr_out  = wr_en & (reg_sel == 4'd1);
    assign wr_set  = wr_en & (reg_sel == 4'd2);
    assign wr_clr  = wr_en & (reg_sel == 4'd3);
    assign wr_rise = wr_en & (reg_sel == 4'd5);
    assign wr_fall = wr_en & (reg_sel == 4'd6);
    assign wr_stat = wr_en & (reg_sel == 4'd7);
    assign wr_deb  = wr_en & (reg_sel == 4'd8);

    // Write data replicated over all banks and masked to the addressed bank's
    // real pins, so every register update is a plain vector merge.
    logic [PadW-1:0] pin_mask, bank_mask, wbits, in_pad, set_pad;

    always_comb begin
        pin_mask = '0;
        pin_mask[NrGPIOs-1:0] = '1;
        bank_mask = '0;
        for (int b = 0; b < NrBanks; b++) begin
            if (int'(bank_idx) == b) begin
                bank_mask[b*DATA_WIDTH +: DATA_WIDTH] = '1;
            end
        end
        bank_mask = bank_mask & pin_mask;
        wbits     = {NrBanks{apb.pwdata}} & bank_mask;
    end

    // ---------------- read path ----------------
    logic [PadW-1:0]       rd_vec;
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        rd_vec = '0;
        case (reg_sel)
            4'd0:    rd_vec = dir_q;
            4'd1:    rd_vec = out_q;
            4'd4:    rd_vec = in_pad;
            4'd5:    rd_vec = rise_en_q;
            4'd6:    rd_vec = fall_en_q;
            4'd7:    rd_vec = status_q;
            default: rd_vec = '0;
        endcase
        rdata = '0;
        for (int b = 0; b < NrBanks; b++) begin
            if (int'(bank_idx) == b) begin
                rdata = rd_vec[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (reg_sel == 4'd8) begin
            rdata = DATA_WIDTH'(debounce_q);
        end
    end

    // Response is gated by reset so an in-flight transfer is dropped at once
    assign apb.pready  = access & ~rst_i;
    assign apb.pslverr = access & err & ~rst_i;
    assign apb.prdata  = (access & ~apb.pwrite & ~err & ~rst_i) ? rdata : '0;

    // ---------------- input synchroniser / debounce ----------------
    logic               tick;
    logic [NrGPIOs-1:0] stable, rise, fall;

    assign tick   = (debounce_q != '0) && (presc_q == debounce_q);
    assign stable = ~(sync2_q ^ sample_q);
    assign rise   = filt_reg_q & ~filt_q;
    assign fall   = ~filt_reg_q & filt_q;

    always_comb begin
        in_pad = '0;
        in_pad[NrGPIOs-1:0] = filt_reg_q;
        set_pad = '0;
        set_pad[NrGPIOs-1:0] = (rise & rise_en_q[NrGPIOs-1:0])
                             | (fall & fall_en_q[NrGPIOs-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sample_q   <= '0;
            filt_reg_q <= '0;
            filt_q     <= '0;
            presc_q    <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_reg_q;

            if (wr_deb || debounce_q == '0 || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            // Bypass keeps sample_q tracking so enabling debounce starts clean
            if (debounce_q == '0) begin
                filt_reg_q <= sync2_q;
                sample_q   <= sync2_q;
            end else if (tick) begin
                sample_q   <= sync2_q;
                filt_reg_q <= (filt_reg_q & ~stable) | (sync2_q & stable);
            end
        end
    end

    // ---------------- register file ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q      <= '0;
            out_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            debounce_q <= '0;
        end else begin
            if (wr_dir)  dir_q     <= (dir_q & ~bank_mask) | wbits;
            if (wr_rise) rise_en_q <= (rise_en_q & ~bank_mask) | wbits;
            if (wr_fall) fall_en_q <= (fall_en_q & ~bank_mask) | wbits;
            if (wr_out)      out_q <= (out_q & ~bank_mask) | wbits;
            else if (wr_set) out_q <= out_q | wbits;
            else if (wr_clr) out_q <= out_q & ~wbits;
            if (wr_deb)  debounce_q <= apb.pwdata[DebounceWidth-1:0];
            // New events are OR-ed after the clear so a same-cycle set wins
            status_q <= (status_q & ~(wr_stat ? wbits : '0)) | set_pad;
        end
    end

    assign gpio_out       = out_q[NrGPIOs-1:0];
    assign gpio_tx_en_o   = dir_q[NrGPIOs-1:0];
    assign gpio_in_sync_o = filt_reg_q;
    assign interrupt_o    = |status_q;

endmodule
